// File: rtl/i2c_pkg.sv
// Shared constants for the I2C input front end: default synchroniser/filter
// depths and the idle (released) bus level.
`timescale 1ns/1ps
package i2c_pkg;
  localparam int   I2C_SYNC_STAGES_DEF = 2;
  localparam int   I2C_FILT_CNT_DEF    = 3;
  localparam logic I2C_IDLE            = 1'b1;
endpackage

// File: rtl/i2c_glitch_filter.sv
// One bus line: flop-chain synchroniser followed by a consecutive-sample
// counter filter. f_next exposes the value out_f takes at the next edge.
`timescale 1ns/1ps
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
  parameter int FILT_CNT    = I2C_FILT_CNT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic out_f,
  output logic f_next
);
  localparam int CNT_W = $clog2(FILT_CNT + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // The level only moves on the FILT_CNT-th differing sample in a row.
  always_comb begin
    f_next   = out_f;
    cnt_next = '0;
    if (s != out_f) begin
      if (cnt == CNT_W'(FILT_CNT - 1))
        f_next = s;
      else
        cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= {SYNC_STAGES{I2C_IDLE}};
      out_f <= I2C_IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], in_i};
      out_f <= f_next;
      cnt   <= cnt_next;
    end
  end
endmodule

// File: rtl/i2c_bus_frontend.sv
// Conditions raw SCL/SDA pads and produces clean, clk-aligned SCL edge,
// START/STOP event pulses and a bus_busy flag for the slave FSM.
`timescale 1ns/1ps
module i2c_bus_frontend
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
  parameter int FILT_CNT    = I2C_FILT_CNT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy
);
  logic [1:0] pads;
  logic [1:0] lvl;
  logic [1:0] lvl_next;
  logic       scl_n;
  logic       sda_n;

  assign pads = {sda_i, scl_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    i2c_glitch_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CNT   (FILT_CNT)
    ) u_filt (
      .clk   (clk),
      .reset (reset),
      .in_i  (pads[gi]),
      .out_f (lvl[gi]),
      .f_next(lvl_next[gi])
    );
  end

  assign scl_f = lvl[0];
  assign sda_f = lvl[1];
  assign scl_n = lvl_next[0];
  assign sda_n = lvl_next[1];

  // Pulses are built from the filters' next levels so they register on the
  // same edge the new filtered level appears. SCL must be high on both sides
  // of an SDA edge, which suppresses START/STOP on simultaneous changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      scl_rise  <= scl_n & ~scl_f;
      scl_fall  <= ~scl_n & scl_f;
      start_det <= scl_f & scl_n & sda_f & ~sda_n;
      stop_det  <= scl_f & scl_n & ~sda_f & sda_n;
      if (start_det)
        bus_busy <= 1'b1;
      else if (stop_det)
        bus_busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed bench for the I2C input front end (default parameters, 2 ns clock).
`timescale 1ns/1ps
module tb_i2c_bus_frontend;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_i = 1'b0;
  logic sda_i = 1'b0;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy;

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int n_rise, n_fall, n_start, n_stop, n_both, n_notbusy;
  int t_rise, t_fall;

  i2c_bus_frontend dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_f    (scl_f),
    .sda_f    (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .bus_busy (bus_busy)
  );

  always #1 clk = ~clk;

  task automatic clr;
    n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_both = 0; n_notbusy = 0;
    t_rise = -1; t_fall = -1;
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic step;
    @(negedge clk);
    cyc++;
    if (scl_rise === 1'b1) begin n_rise++; t_rise = cyc; end
    if (scl_fall === 1'b1) begin n_fall++; t_fall = cyc; end
    if (start_det === 1'b1) n_start++;
    if (stop_det === 1'b1) n_stop++;
    if (start_det === 1'b1 && stop_det === 1'b1) n_both++;
    if (bus_busy !== 1'b1) n_notbusy++;
  endtask

  task automatic test_reset;
    reset = 1'b1; scl_i = 1'b0; sda_i = 1'b0;
    repeat (4) step();
    vec++;
    if ({scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy} !== 7'b1100000) begin
      errs++;
      $display("FAIL reset_state got %b want 1100000",
               {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy});
    end
    scl_i = 1'b1; sda_i = 1'b1;
    step();
    reset = 1'b0;
    clr();
    repeat (20) step();
    vec++;
    if (n_rise + n_fall + n_start + n_stop != 0) begin
      errs++;
      $display("FAIL reset_release_pulses got %0d want 0", n_rise + n_fall + n_start + n_stop);
    end
    vec++;
    if ({scl_f, sda_f, bus_busy} !== 3'b110) begin
      errs++;
      $display("FAIL reset_release_levels got %b want 110", {scl_f, sda_f, bus_busy});
    end
  endtask

  task automatic test_glitch;
    int c0;
    int lat;
    clr();
    sda_i = 1'b0;
    step(); step();
    sda_i = 1'b1;
    repeat (10) step();
    vec++;
    if (sda_f !== 1'b1 || n_start != 0) begin
      errs++;
      $display("FAIL glitch_2cyc got sda_f=%b starts=%0d want sda_f=1 starts=0", sda_f, n_start);
    end
    clr();
    lat = -1;
    c0 = cyc;
    sda_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cyc - c0 == 4) sda_i = 1'b1;
      if (lat < 0 && sda_f === 1'b0) lat = cyc - c0;
    end
    vec++;
    if (lat != 5) begin
      errs++;
      $display("FAIL glitch_4cyc_latency got %0d want 5", lat);
    end
    vec++;
    if (n_start != 1 || n_stop != 1 || n_both != 0) begin
      errs++;
      $display("FAIL glitch_4cyc_events got start=%0d stop=%0d both=%0d want 1 1 0",
               n_start, n_stop, n_both);
    end
    vec++;
    if (bus_busy !== 1'b0) begin
      errs++;
      $display("FAIL glitch_4cyc_busy got %b want 0", bus_busy);
    end
  endtask

  task automatic test_start_data;
    logic       found;
    logic [7:0] pat;
    pat = 8'b1001_0110;
    clr();
    found = 1'b0;
    sda_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (start_det === 1'b1) begin found = 1'b1; break; end
    end
    vec++;
    if (!found) begin
      errs++;
      $display("FAIL start_seen got 0 want 1 (timeout)");
    end
    vec++;
    if (bus_busy !== 1'b0 || sda_f !== 1'b0) begin
      errs++;
      $display("FAIL start_cycle got busy=%b sda_f=%b want busy=0 sda_f=0", bus_busy, sda_f);
    end
    step();
    vec++;
    if (start_det !== 1'b0 || bus_busy !== 1'b1) begin
      errs++;
      $display("FAIL start_after got start=%b busy=%b want 0 1", start_det, bus_busy);
    end
    repeat (15) step();
    clr();
    scl_i = 1'b0;
    repeat (20) step();
    for (int b = 7; b >= 0; b--) begin
      sda_i = pat[b];
      repeat (20) step();
      scl_i = 1'b1;
      repeat (20) step();
      scl_i = 1'b0;
      repeat (20) step();
    end
    vec++;
    if (n_rise != 8 || n_fall != 9) begin
      errs++;
      $display("FAIL data_scl_edges got rise=%0d fall=%0d want 8 9", n_rise, n_fall);
    end
    vec++;
    if (t_fall - t_rise != 20) begin
      errs++;
      $display("FAIL data_edge_spacing got %0d want 20", t_fall - t_rise);
    end
    vec++;
    if (n_start != 0 || n_stop != 0 || bus_busy !== 1'b1) begin
      errs++;
      $display("FAIL data_no_events got start=%0d stop=%0d busy=%b want 0 0 1",
               n_start, n_stop, bus_busy);
    end
  endtask

  task automatic test_stop;
    logic found;
    scl_i = 1'b1;
    repeat (20) step();
    found = 1'b0;
    sda_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (stop_det === 1'b1) begin found = 1'b1; break; end
    end
    vec++;
    if (!found || bus_busy !== 1'b1) begin
      errs++;
      $display("FAIL stop_cycle got seen=%b busy=%b want 1 1", found, bus_busy);
    end
    step();
    vec++;
    if (stop_det !== 1'b0 || bus_busy !== 1'b0) begin
      errs++;
      $display("FAIL stop_after got stop=%b busy=%b want 0 0", stop_det, bus_busy);
    end
    repeat (10) step();
    clr();
    scl_i = 1'b0; repeat (20) step();
    sda_i = 1'b0; repeat (20) step();
    scl_i = 1'b1; repeat (20) step();
    sda_i = 1'b1; repeat (20) step();
    vec++;
    if (n_stop != 1 || n_start != 0 || bus_busy !== 1'b0) begin
      errs++;
      $display("FAIL idle_stop got stop=%0d start=%0d busy=%b want 1 0 0", n_stop, n_start, bus_busy);
    end
  endtask

  task automatic test_repeated_start;
    sda_i = 1'b0;
    repeat (20) step();
    clr();
    scl_i = 1'b0; repeat (20) step();
    sda_i = 1'b1; repeat (20) step();
    scl_i = 1'b1; repeat (20) step();
    sda_i = 1'b0; repeat (20) step();
    vec++;
    if (n_start != 1 || n_stop != 0 || n_notbusy != 0) begin
      errs++;
      $display("FAIL rep_start got start=%0d stop=%0d idle_cycles=%0d want 1 0 0",
               n_start, n_stop, n_notbusy);
    end
    clr();
    scl_i = 1'b0; sda_i = 1'b1;
    repeat (20) step();
    vec++;
    if (n_fall != 1 || n_stop != 0 || n_start != 0) begin
      errs++;
      $display("FAIL simul_fall got fall=%0d stop=%0d start=%0d want 1 0 0", n_fall, n_stop, n_start);
    end
    clr();
    scl_i = 1'b1; sda_i = 1'b0;
    repeat (20) step();
    vec++;
    if (n_rise != 1 || n_start != 0 || n_stop != 0 || bus_busy !== 1'b1) begin
      errs++;
      $display("FAIL simul_rise got rise=%0d start=%0d stop=%0d busy=%b want 1 0 0 1",
               n_rise, n_start, n_stop, bus_busy);
    end
  endtask

  task automatic test_reset_mid;
    scl_i = 1'b0;
    repeat (20) step();
    vec++;
    if (scl_f !== 1'b0 || bus_busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_precond got scl_f=%b busy=%b want 0 1", scl_f, bus_busy);
    end
    clr();
    reset = 1'b1;
    #0.5;
    vec++;
    if ({scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy} !== 7'b1100000) begin
      errs++;
      $display("FAIL mid_reset_async got %b want 1100000",
               {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy});
    end
    repeat (4) step();
    scl_i = 1'b1; sda_i = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    vec++;
    if (n_rise + n_fall + n_start + n_stop != 0 || bus_busy !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_after got pulses=%0d busy=%b want 0 0",
               n_rise + n_fall + n_start + n_stop, bus_busy);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_glitch();
    test_start_data();
    test_stop();
    test_repeated_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
